// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer so a fetch already in
// flight when ID stalls is captured instead of lost; also counts stalled ID cycles.
module if_id_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_ID_reg_stall,
  input  logic        flush_IF_ID,
  input  logic        valid_IF,
  input  logic [31:0] pc_IF,
  input  logic [31:0] inst_sram_rdata,
  input  logic        adel_IF,
  output logic        ready_IF,
  output logic        valid_ID,
  output logic [31:0] pc_ID,
  output logic [31:0] inst_ID,
  output logic        adel_ID,
  output logic [31:0] stall_cnt
);

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            adel;
  } entry_t;

  // Bit 0 is "ID valid", bit 1 is "skid valid"; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } state_e;

  localparam logic [XLEN-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  entry_t          id_q, id_d;
  entry_t          skid_q, skid_d;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  entry_t          fetch;
  logic            skid_valid;

  assign fetch = '{pc: pc_IF, inst: inst_sram_rdata, adel: adel_IF};

  // State and payload registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_EMPTY;
      id_q        <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state: flush beats stall, stall holds a live ID and parks a fetch in the skid
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    if (!flush_IF_ID && IF_ID_reg_stall && state_q[0] && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + XLEN'(1);
    end

    if (flush_IF_ID) begin
      state_d = S_EMPTY;
    end else if (!IF_ID_reg_stall) begin
      if (state_q == S_TWO) begin
        id_d    = skid_q;
        state_d = S_ONE;
      end else if (valid_IF) begin
        id_d    = fetch;
        state_d = S_ONE;
      end else begin
        state_d = S_EMPTY;
      end
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (valid_IF) begin
            id_d    = fetch;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (valid_IF) begin
            skid_d  = fetch;
            state_d = S_TWO;
          end
        end
        default: ;
      endcase
    end
  end

  assign skid_valid = state_q[1];
  assign ready_IF   = ~IF_ID_reg_stall & ~skid_valid;
  assign valid_ID   = state_q[0];
  assign pc_ID      = id_q.pc;
  assign inst_ID    = id_q.inst;
  assign adel_ID    = id_q.adel;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  input  1  sole clock, all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- IF_ID_reg_stall  input  1  hold ID contents; driven by the hazard detection unit
- flush_IF_ID  input  1  discard all held instructions (branch redirect/exception)
- valid_IF  input  1  inst_sram_rdata/pc_IF/adel_IF carry a fetched instruction this cycle
- pc_IF  input  32  PC of the instruction on inst_sram_rdata
- inst_sram_rdata  input  32  instruction word, 1 cycle after the request was issued
- adel_IF  input  1  fetch address error for pc_IF
- ready_IF  output  1  IF may issue a fetch request this cycle
- valid_ID  output  1  ID holds a live instruction
- pc_ID  output  32  PC of ID instruction
- inst_ID  output  32  ID instruction word
- adel_ID  output  1  fetch address error of ID instruction
- stall_cnt  output  32  performance counter of stalled ID cycles
REQ-002 SHALL have no parameters; all widths are fixed.

Function
REQ-003 SHALL hold two entries: the ID register (valid_ID, pc_ID, inst_ID, adel_ID) and a one-entry skid buffer (skid_valid + same fields).
REQ-004 SHALL track state EMPTY (both invalid), ONE (ID valid, skid invalid), TWO (both valid); ID invalid with skid valid SHALL be unreachable.
REQ-005 ready_IF SHALL be combinational: ~IF_ID_reg_stall & ~skid_valid.
REQ-006 With flush_IF_ID=1: next state EMPTY, valid_ID=0, skid_valid=0, and a same-cycle valid_IF SHALL be discarded; flush has priority over stall and over every input.
REQ-007 With no flush and stall=0: ID loads the skid entry if skid_valid (skid clears; a same-cycle valid_IF cannot occur per REQ-005), else loads the IF inputs with valid_ID=valid_IF.
REQ-008 With no flush and stall=1: ID register unchanged; a valid_IF SHALL be written into the skid buffer (ONE->TWO, EMPTY->ONE writes into ID directly, since an empty ID has nothing to hold).
REQ-009 EMPTY with stall=1 and valid_IF=1 SHALL load the instruction into ID (valid_ID=1); stall only holds live contents.
REQ-010 Latency: an instruction with valid_IF in cycle N and no stall/flush SHALL appear on valid_ID/pc_ID/inst_ID in cycle N+1.
REQ-011 valid_IF=1 while in TWO is a protocol violation; the input SHALL be dropped and state unchanged (bench asserts it never happens).
REQ-012 pc_ID/inst_ID/adel_ID SHALL change only on a load; flush clears valid bits only, data fields keep old values.
REQ-013 Order SHALL be preserved: the skid entry always reaches ID before any later fetch.
REQ-014 stall_cnt SHALL increment by 1 each cycle with IF_ID_reg_stall=1, valid_ID=1 and flush_IF_ID=0, saturating at 0xFFFFFFFF (no wrap).

Reset
REQ-015 resetn=0 SHALL immediately, without a clock, force state EMPTY, valid_ID=0, skid_valid=0, pc_ID=0, inst_ID=0, adel_ID=0, stall_cnt=0.
REQ-016 After reset release with stall=0, ready_IF SHALL be 1 in the first cycle.
REQ-017 Reset asserted mid-operation (any state, including TWO) SHALL discard all held instructions; no instruction from before reset SHALL appear on valid_ID.

Verification
REQ-018 Stream: valid_IF=1, pc_IF 0xBFC00000, +4, +8 in cycles 1-3, stall=0 -> pc_ID 0xBFC00000, +4, +8 with valid_ID=1 in cycles 2-4.
REQ-019 Skid: ID holds 0x100, stall=1 in cycle N while valid_IF brings 0x104 -> ready_IF=0, pc_ID stays 0x100; stall=0 in N+1 -> pc_ID=0x104 in N+2, ready_IF=1 in N+2.
REQ-020 Flush in TWO with same-cycle valid_IF=1 and stall=1 -> valid_ID=0, skid empty, ready_IF=1 next cycle once stall=0, discarded PCs never appear.
REQ-021 Counter: 5 stalled cycles with valid_ID=1 -> stall_cnt=5; preload via force to 0xFFFFFFFE, 3 stalled cycles -> 0xFFFFFFFF.
REQ-022 Asynchronous resetn pulse between clock edges in TWO -> valid_ID=0 and stall_cnt=0 before the next edge; adel_IF=1 with pc_IF 0x3 then flows to adel_ID=1, pc_ID=0x3.
